// File: rtl/key_schedule_ctrl_pkg.sv
// Shared AES definitions for the round-key sequencer: widths, FSM state
// encoding, round-index type and the Rcon table.
package key_schedule_ctrl_pkg;

  localparam int AES_KEY_W = 128;
  localparam int AES_NR    = 10;

  typedef logic [3:0] round_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } ks_state_t;

  // Rcon for rounds 1..10, stored at index round-1.
  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant for a round index; rounds outside 1..10 map to 00.
  function automatic logic [7:0] rcon_of(input round_t r);
    logic [7:0] v;
    v = 8'h00;
    if (r >= 4'd1 && r <= 4'd10) v = RCON[r - 4'd1];
    return v;
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Link between the round-key sequencer (master) and the key-expansion
// stage (slave).
interface key_schedule_ctrl_if;
  import key_schedule_ctrl_pkg::*;

  // Protocol: exp_start is the valid of an expansion request carrying
  // exp_key/exp_rcon. The master holds it high for exactly two consecutive
  // cycles with the payload unchanged: the stage registers the inputs on the
  // first edge and its result on the second. There is no ready: the stage
  // always accepts, and exp_key_d is valid in the cycle after the pair and
  // held for as long as exp_start stays low.
  logic                 exp_start;
  logic [AES_KEY_W-1:0] exp_key;
  logic [7:0]           exp_rcon;
  logic [AES_KEY_W-1:0] exp_key_d;

  modport master (output exp_start, exp_key, exp_rcon, input exp_key_d);
  modport slave  (input exp_start, exp_key, exp_rcon, output exp_key_d);

endinterface

// File: rtl/key_schedule_ctrl_rk_file.sv
// Round-key file: 11 x 128-bit registers, one write port, one registered
// read port with range check. With KEY_SCHED_DEC_ORDER_EN defined, rd_dec
// reverses the index so keys can be served in decryption order.
module aes_rk_file
  import key_schedule_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  round_t               wr_addr,
  input  logic [AES_KEY_W-1:0] wr_data,
  input  logic                 rd_en,
  input  round_t               rd_addr,
`ifdef KEY_SCHED_DEC_ORDER_EN
  input  logic                 rd_dec,
`endif
  output logic [AES_KEY_W-1:0] rd_key
);

  localparam round_t LAST = round_t'(AES_NR);

  logic [AES_KEY_W-1:0] rk_q [AES_NR+1];
  round_t               rd_idx;
  logic                 rd_in_range;

  // Effective read index and range check (range is judged on the raw address).
  always_comb begin
    rd_in_range = (rd_addr <= LAST);
    rd_idx      = rd_addr;
`ifdef KEY_SCHED_DEC_ORDER_EN
    if (rd_dec) rd_idx = LAST - rd_addr;
`endif
  end

  // Key storage and registered read; unreadable requests return zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rk_q   <= '{default: '0};
      rd_key <= '0;
    end else begin
      if (wr_en && wr_addr <= LAST) rk_q[wr_addr] <= wr_data;
      if (rd_en && rd_in_range) rd_key <= rk_q[rd_idx];
      else                      rd_key <= '0;
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 round-key sequencer. Drives an external expansion stage one round
// at a time (ISSUE/CAPTURE strobe pair, then WRITE) and stores the 11 round
// keys in aes_rk_file. Optional macro KEY_SCHED_DEC_ORDER_EN adds rd_dec for
// reverse-order reads.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [AES_KEY_W-1:0] cipher_key,
  output logic                 busy,
  output logic                 ready,
  key_schedule_ctrl_if.master  exp_bus,
  input  round_t               rd_addr,
`ifdef KEY_SCHED_DEC_ORDER_EN
  input  logic                 rd_dec,
`endif
  output logic [AES_KEY_W-1:0] rd_key,
  output ks_state_t            dbg_state
);

  localparam round_t LAST = round_t'(NR);

  ks_state_t            state_q, state_d;
  round_t               round_q, round_d;
  logic [AES_KEY_W-1:0] cur_key_q, cur_key_d;
  logic                 rk_we;
  round_t               rk_waddr;
  logic [AES_KEY_W-1:0] rk_wdata;

  assign dbg_state = state_q;

  // State, round counter and feed-back key registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      round_q   <= '0;
      cur_key_q <= '0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      cur_key_q <= cur_key_d;
    end
  end

  // Next state, round-key writes and stage-facing outputs.
  always_comb begin
    state_d           = state_q;
    round_d           = round_q;
    cur_key_d         = cur_key_q;
    rk_we             = 1'b0;
    rk_waddr          = round_q;
    rk_wdata          = exp_bus.exp_key_d;
    busy              = 1'b0;
    ready             = 1'b0;
    exp_bus.exp_start = 1'b0;
    exp_bus.exp_key   = '0;
    exp_bus.exp_rcon  = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // ready stays up during the load cycle and drops on the next one.
        ready = (state_q == ST_DONE);
        if (load) begin
          rk_we     = 1'b1;
          rk_waddr  = '0;
          rk_wdata  = cipher_key;
          cur_key_d = cipher_key;
          round_d   = 4'd1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_CAPTURE: begin
        busy              = 1'b1;
        exp_bus.exp_start = 1'b1;
        exp_bus.exp_key   = cur_key_q;
        exp_bus.exp_rcon  = rcon_of(round_q);
        state_d           = (state_q == ST_ISSUE) ? ST_CAPTURE : ST_WRITE;
      end
      ST_WRITE: begin
        busy      = 1'b1;
        rk_we     = 1'b1;
        cur_key_d = exp_bus.exp_key_d;
        if (round_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  aes_rk_file u_rk_file (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (rk_we),
    .wr_addr (rk_waddr),
    .wr_data (rk_wdata),
    .rd_en   (ready),
    .rd_addr (rd_addr),
`ifdef KEY_SCHED_DEC_ORDER_EN
    .rd_dec  (rd_dec),
`endif
    .rd_key  (rd_key)
  );

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl with a behavioural AES-128 expansion stage
// attached to the exp_* link and a word-level FIPS-197 reference model.
module tb_key_schedule_ctrl;
  import key_schedule_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         resetn;
  logic         load;
  logic [127:0] cipher_key;
  logic         busy, ready;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  ks_state_t    dbg_state;
`ifdef KEY_SCHED_DEC_ORDER_EN
  logic         rd_dec;
`endif

  key_schedule_ctrl_if exp_if ();

  key_schedule_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .cipher_key (cipher_key),
    .busy       (busy),
    .ready      (ready),
    .exp_bus    (exp_if),
    .rd_addr    (rd_addr),
`ifdef KEY_SCHED_DEC_ORDER_EN
    .rd_dec     (rd_dec),
`endif
    .rd_key     (rd_key),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_q[$];
  int           tag_q[$];
  logic [7:0]   iss_rcon_q[$];
  logic [127:0] iss_key_q[$];
  logic [127:0] ref_rk [11];
  logic [7:0]   rcon_ref [11];
  bit           model_valid = 1'b0;
  bit           mon_en = 1'b0;
  logic         rd_req = 1'b0;
  logic         rd_vld = 1'b0;
  int           strobe_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (a^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  // One expansion round, as the hardware stage performs it.
  function automatic logic [127:0] stage_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_rot(k[31:0]) ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Reference: full FIPS-197 word expansion w[0..43], Rcon by doubling.
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_rot(t) ^ {rc, 24'h0};
        rcon_ref[i/4] = rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_read(input logic [3:0] a, input bit dec);
    if (!model_valid || a > 4'd10) return '0;
    return dec ? ref_rk[10 - int'(a)] : ref_rk[a];
  endfunction

  // ---------------- expansion stage (behavioural) ----------------
  logic         st_phase;
  logic [127:0] st_key;
  logic [7:0]   st_rcon;
  always @(posedge clk) begin
    if (!resetn) begin
      st_phase         <= 1'b0;
      st_key           <= '0;
      st_rcon          <= '0;
      exp_if.exp_key_d <= '0;
    end else begin
      if (exp_if.exp_start && !st_phase) begin
        st_key  <= exp_if.exp_key;
        st_rcon <= exp_if.exp_rcon;
      end
      if (exp_if.exp_start && st_phase) exp_if.exp_key_d <= stage_round(st_key, st_rcon);
      st_phase <= exp_if.exp_start && !st_phase;
    end
  end

  // Read-latency tracker: a request presented in one cycle returns next cycle.
  always @(posedge clk) rd_vld <= rd_req;

  // ---------------- monitor ----------------
  initial begin
    int         run;
    logic [7:0] c_rc;
    logic [127:0] c_key;
    run = 0; c_rc = '0; c_key = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rd_vld) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rd_unexpected actual=%h required=no_read", rd_key);
          end else begin
            check($sformatf("rd_key[%0d]", tag_q.pop_front()), rd_key, exp_q.pop_front());
          end
        end
        if (exp_if.exp_start) begin
          if (run == 0) begin
            if (iss_rcon_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL issue_unexpected actual=rcon_%h required=no_issue", exp_if.exp_rcon);
              c_rc = exp_if.exp_rcon; c_key = exp_if.exp_key;
            end else begin
              c_rc  = iss_rcon_q.pop_front();
              c_key = iss_key_q.pop_front();
              check("issue_rcon", exp_if.exp_rcon, c_rc);
              check("issue_key", exp_if.exp_key, c_key);
            end
          end else begin
            check("capture_rcon_hold", exp_if.exp_rcon, c_rc);
            check("capture_key_hold", exp_if.exp_key, c_key);
          end
          run++;
          strobe_cnt++;
        end else begin
          if (run != 0) check("strobe_pair_len", run, 2);
          run = 0;
          check("idle_rcon_zero", exp_if.exp_rcon, 0);
          check("idle_key_zero", exp_if.exp_key, 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_read_exp(input logic [3:0] a, input bit dec, input logic [127:0] e);
    rd_addr = a;
    rd_req  = 1'b1;
`ifdef KEY_SCHED_DEC_ORDER_EN
    rd_dec  = dec;
`endif
    exp_q.push_back(e);
    tag_q.push_back(dec ? 100 + int'(a) : int'(a));
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input bit dec);
    do_read_exp(a, dec, model_read(a, dec));
  endtask

  // Load a key and walk the 30 expansion cycles with background reads.
  // collide: second load of key 0 at cycle 12. abort_c: reset at that cycle.
  task automatic run_expansion(input logic [127:0] key, input bit collide, input int abort_c);
    model_expand(key);
    model_valid = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      iss_rcon_q.push_back(rcon_ref[r]);
      iss_key_q.push_back(ref_rk[r-1]);
    end
    strobe_cnt = 0;
    rd_req     = 1'b0;
    load       = 1'b1;
    cipher_key = key;
    @(negedge clk);
    load = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 1) begin
        check("busy_cycle1", busy, 1);
        check("ready_drop_cycle1", ready, 0);
      end
      if (c == 30) check("ready_cycle30", ready, 0);
      if (abort_c != 0 && c == abort_c) begin
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("busy_after_reset", busy, 0);
        check("ready_after_reset", ready, 0);
        iss_rcon_q.delete();
        iss_key_q.delete();
        return;
      end
      load = (collide && c == 12);
      if (collide && c == 12) cipher_key = '0;
      do_read(4'($urandom_range(0, 15)), 1'b0);
    end
    load = 1'b0;
    check("ready_cycle31", ready, 1);
    check("busy_cycle31", busy, 0);
    check("strobe_count", strobe_cnt, 20);
    check("issues_consumed", iss_rcon_q.size(), 0);
    model_valid = 1'b1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k;
    resetn = 1'b0; load = 1'b0; cipher_key = '0; rd_addr = '0;
`ifdef KEY_SCHED_DEC_ORDER_EN
    rd_dec = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_busy", busy, 0);
    check("reset_ready", ready, 0);
    check("reset_exp_start", exp_if.exp_start, 0);
    check("reset_exp_rcon", exp_if.exp_rcon, 0);
    check("reset_exp_key", exp_if.exp_key, 0);
    check("reset_rd_key", rd_key, 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Reads in IDLE return zero.
    for (int a = 0; a < 4; a++) do_read(4'($urandom_range(0, 15)), 1'b0);

    // FIPS-197 key.
    run_expansion(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 0);
    do_read_exp(4'd1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);
    do_read_exp(4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int a = 0; a < 16; a++) do_read(4'(a), 1'b0);
`ifdef KEY_SCHED_DEC_ORDER_EN
    do_read_exp(4'd0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_read_exp(4'd10, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int a = 0; a < 16; a++) do_read(4'(a), 1'b1);
`endif

    // Reload from DONE with a colliding load of key 0 at cycle 12.
    k = rand_key();
    run_expansion(k, 1'b1, 0);
    for (int a = 0; a < 16; a++) do_read(4'(a), 1'b0);

    // Reset in the middle of an expansion, then a fresh load.
    run_expansion(rand_key(), 1'b0, 15);
    model_valid = 1'b0;
    for (int a = 0; a < 16; a++) do_read(4'(a), 1'b0);
    run_expansion(rand_key(), 1'b0, 0);
    for (int a = 0; a < 16; a++) do_read(4'(a), 1'b0);

    // Random keys with random reads.
    for (int n = 0; n < 3; n++) begin
      run_expansion(rand_key(), 1'b0, 0);
      for (int i = 0; i < 12; i++) begin
`ifdef KEY_SCHED_DEC_ORDER_EN
        do_read(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
`else
        do_read(4'($urandom_range(0, 15)), 1'b0);
`endif
      end
    end

    rd_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reads_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
